fwd_select_unit: RTL
====================

FWD_SELECT_UNIT -- requirements
Module: fwd_select_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages (T1..T3); only 3 is supported.
REQ-003 SHALL have port CLK input 1: single clock, rising edge.
REQ-004 SHALL have port RESETN input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ID_VALID input 1: a decoded instruction is present in ID.
REQ-006 SHALL have ports ID_RS1 and ID_RS2, input REG_AW: source registers.
REQ-007 SHALL have port ID_RD input REG_AW: destination register.
REQ-008 SHALL have port ID_WE input 1: the instruction writes ID_RD.
REQ-009 SHALL have port ID_IS_LOAD input 1: the result comes from memory.
REQ-010 SHALL have port ID_ALT_B input 1: operand B is immediate/PC.
REQ-011 SHALL have port STALL_IN input 1: global pipeline freeze.
REQ-012 SHALL have port FLUSH input 1: kill the ID and EX instructions.
REQ-013 SHALL have ports SEL_A and SEL_B, output 3: registered select for the EX-stage 5:1 operand muxes.
REQ-014 SHALL have port HAZARD output 1: combinational load-use stall request to the fetch/decode stage.

Function
REQ-015 Select encoding SHALL be: 000 regfile, 001 T1 result (EX/MEM ALU), 010 T2 result (MEM/WB), 011 T3 result (WB latch), 100 alternate operand; 101-111 are never driven.
REQ-016 Tracker entries T1..T3 SHALL each hold {valid, rd, we, is_load}; T1 is the instruction immediately ahead of ID.
REQ-017 A match SHALL require: valid, we, rd equal to rs, and rd != 0; x0 never forwards.
REQ-018 Match priority SHALL be T1 > T2 > T3 > regfile (youngest wins).
REQ-019 HAZARD SHALL be 1 when ID_VALID and T1.is_load matches rs1, or matches rs2 with ID_ALT_B=0; otherwise 0.
REQ-020 On an advance edge (STALL_IN=0, FLUSH=0, HAZARD=0), SEL_A/SEL_B SHALL capture the computed selects, and the tracker SHALL shift: T3<=T2, T2<=T1, T1<={ID_VALID, ID_RD, ID_WE, ID_IS_LOAD}.
REQ-021 SEL_B SHALL be 100 whenever ID_ALT_B=1, regardless of rs2 matches.
REQ-022 On a hazard edge, the unit SHALL insert a bubble (T1.valid<=0, T2<=T1, T3<=T2) and set SEL_A and SEL_B to 000; the ID instruction is reissued next cycle and then matches T2 (select 010).
REQ-023 On a STALL_IN edge, all state SHALL hold; HAZARD SHALL still be evaluated combinationally.
REQ-024 On a FLUSH edge, T1.valid SHALL be cleared, SEL_A and SEL_B SHALL become 000, T2<=T1, and T3<=T2.
REQ-025 Priority SHALL be FLUSH > STALL_IN > hazard bubble > advance.
REQ-026 Select latency SHALL be one cycle: ID decision -> SEL valid during the EX cycle.

Reset
REQ-027 RESETN=0 SHALL asynchronously clear all tracker valid bits and set SEL_A=000 and SEL_B=000; HAZARD therefore reads 0.
REQ-028 Deassertion of RESETN SHALL be honoured at the next rising edge; reset asserted mid-hazard SHALL drop the bubble.

Configuration
REQ-029 With FWD_WB_BYPASS_EN defined, T3 SHALL be tracked and select 011 SHALL be used.
REQ-030 Without FWD_WB_BYPASS_EN, T3 SHALL not exist, select 011 SHALL never be driven, and a T3-only match SHALL yield 000 (regfile write-before-read).

Structure
REQ-031 Shared package SHALL hold the SEL_* encoding constants (SEL_RF, SEL_T1, SEL_T2, SEL_T3, SEL_ALT) and the tracker-entry typedef.
REQ-032 The rs-versus-tracker priority compare SHALL be one sub-module, fwd_match, instantiated once per operand.

Verification
REQ-033 add x5 then add x6,x5,x5 back-to-back -> SEL_A=001 and SEL_B=001 in the second instruction's EX cycle.
REQ-034 lw x7 then add x8,x7,x1 -> HAZARD=1 for one cycle, a bubble with SEL=000, then SEL_A=010.
REQ-035 Writes to x0 followed by a read of x0 -> SEL_A=000, HAZARD=0.
REQ-036 x9 written at T1 and T3 simultaneously -> SEL_A=001; x9 at T3 only -> 011 with FWD_WB_BYPASS_EN, 000 without.
REQ-037 FLUSH asserted together with a load-use hazard -> no bubble, SEL=000, T1 invalid; STALL_IN=1 for 3 cycles -> SEL and tracker unchanged.
REQ-038 RESETN pulled low mid-stream -> SEL_A/SEL_B=000 immediately, no forwarding on the first post-reset instruction.

Source files
------------

// File: rtl/fwd_select_unit_pkg.sv
// rtl/fwd_select_unit_pkg.sv - select encodings and tracker entry type for the forwarding unit
package fwd_select_unit_pkg;

  // Tracker rd fields are stored zero-extended to this width so the package stays width-agnostic
  localparam int RD_MAX_W = 8;

  typedef logic [2:0]          sel_t;
  typedef logic [RD_MAX_W-1:0] rd_t;

  localparam sel_t SEL_RF  = 3'b000;
  localparam sel_t SEL_T1  = 3'b001;
  localparam sel_t SEL_T2  = 3'b010;
  localparam sel_t SEL_T3  = 3'b011;
  localparam sel_t SEL_ALT = 3'b100;

  typedef struct packed {
    logic valid;
    rd_t  rd;
    logic we;
    logic is_load;
  } trk_entry_t;

  function automatic logic trk_hit(input trk_entry_t e, input rd_t rs);
    return e.valid && e.we && (e.rd == rs) && (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select_unit_match.sv
// rtl/fwd_select_unit_match.sv - youngest-first source match against the tracker (fwd_match)
// T3 input and select 011 exist only when FWD_WB_BYPASS_EN is defined.
module fwd_match
  import fwd_select_unit_pkg::*;
(
  input  rd_t        rs_i,
  input  logic       use_alt_i,
  input  trk_entry_t t1_i,
  input  trk_entry_t t2_i,
`ifdef FWD_WB_BYPASS_EN
  input  trk_entry_t t3_i,
`endif
  output logic       t1_load_hit_o,
  output sel_t       sel_o
);

  logic hit1, hit2, hit3;
  logic unused_load_bits;

  assign hit1 = trk_hit(t1_i, rs_i);
  assign hit2 = trk_hit(t2_i, rs_i);
`ifdef FWD_WB_BYPASS_EN
  assign hit3             = trk_hit(t3_i, rs_i);
  assign unused_load_bits = t2_i.is_load ^ t3_i.is_load;
`else
  assign hit3             = 1'b0;
  assign unused_load_bits = t2_i.is_load;
`endif

  // Load-use detection ignores use_alt_i; the top decides whether operand B is really read
  assign t1_load_hit_o = hit1 && t1_i.is_load;

  always_comb begin
    sel_o = SEL_RF;
    if (use_alt_i)  sel_o = SEL_ALT;
    else if (hit1)  sel_o = SEL_T1;
    else if (hit2)  sel_o = SEL_T2;
    else if (hit3)  sel_o = SEL_T3;
  end

endmodule

// File: rtl/fwd_select_unit.sv
// rtl/fwd_select_unit.sv - operand forwarding select and load-use hazard unit
// Optional WB-latch bypass (tracker stage T3, select 011) enabled by FWD_WB_BYPASS_EN.
module fwd_select_unit
  import fwd_select_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              ID_VALID,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_WE,
  input  logic              ID_IS_LOAD,
  input  logic              ID_ALT_B,
  input  logic              STALL_IN,
  input  logic              FLUSH,
  output logic [2:0]        SEL_A,
  output logic [2:0]        SEL_B,
  output logic              HAZARD
);

  if (DEPTH != 3 || REG_AW > RD_MAX_W) begin : g_cfg_check
    $error("fwd_select_unit: unsupported DEPTH or REG_AW");
  end

  trk_entry_t t1_q, t1_d, t2_q, t2_d;
`ifdef FWD_WB_BYPASS_EN
  trk_entry_t t3_q, t3_d;
`endif
  sel_t       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  sel_t       sel_a, sel_b;
  logic       load_hit_a, load_hit_b, hazard;
  rd_t        rs1, rs2;
  trk_entry_t id_entry;

  assign rs1      = rd_t'(ID_RS1);
  assign rs2      = rd_t'(ID_RS2);
  assign id_entry = '{valid: ID_VALID, rd: rd_t'(ID_RD), we: ID_WE, is_load: ID_IS_LOAD};

  fwd_match u_match_a (
    .rs_i          (rs1),
    .use_alt_i     (1'b0),
    .t1_i          (t1_q),
    .t2_i          (t2_q),
`ifdef FWD_WB_BYPASS_EN
    .t3_i          (t3_q),
`endif
    .t1_load_hit_o (load_hit_a),
    .sel_o         (sel_a)
  );

  fwd_match u_match_b (
    .rs_i          (rs2),
    .use_alt_i     (ID_ALT_B),
    .t1_i          (t1_q),
    .t2_i          (t2_q),
`ifdef FWD_WB_BYPASS_EN
    .t3_i          (t3_q),
`endif
    .t1_load_hit_o (load_hit_b),
    .sel_o         (sel_b)
  );

  assign hazard = ID_VALID && (load_hit_a || (load_hit_b && !ID_ALT_B));
  assign HAZARD = hazard;

  // Flush and load-use bubble both retire the ID slot as an invalid T1 entry
  always_comb begin
    t1_d    = t1_q;
    t2_d    = t2_q;
`ifdef FWD_WB_BYPASS_EN
    t3_d    = t3_q;
`endif
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (FLUSH || (!STALL_IN && hazard)) begin
      t1_d    = '0;
      t2_d    = t1_q;
`ifdef FWD_WB_BYPASS_EN
      t3_d    = t2_q;
`endif
      sel_a_d = SEL_RF;
      sel_b_d = SEL_RF;
    end else if (!STALL_IN) begin
      t1_d    = id_entry;
      t2_d    = t1_q;
`ifdef FWD_WB_BYPASS_EN
      t3_d    = t2_q;
`endif
      sel_a_d = sel_a;
      sel_b_d = sel_b;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      t1_q    <= '0;
      t2_q    <= '0;
`ifdef FWD_WB_BYPASS_EN
      t3_q    <= '0;
`endif
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      t1_q    <= t1_d;
      t2_q    <= t2_d;
`ifdef FWD_WB_BYPASS_EN
      t3_q    <= t3_d;
`endif
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign SEL_A = sel_a_q;
  assign SEL_B = sel_b_q;

endmodule
